// File: rtl/pci_arb_pkg.sv
// Shared state encoding and sizing helpers for the PCI bus arbiter.
package pci_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        ACTIVE  = 2'd2,
        TURN    = 2'd3
    } arb_state_t;

    localparam int DEF_NUM_MASTERS = 4;
    localparam int DEF_GNT_TIMEOUT = 16;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int timer_width(input int t);
        return $clog2(t + 1);
    endfunction

    localparam int DEF_IDX_W = idx_width(DEF_NUM_MASTERS);
    localparam int DEF_TMR_W = timer_width(DEF_GNT_TIMEOUT);

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner select: first asserted request above i_last, wrapping.
module rr_pick
    import pci_arb_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int IDX_W       = idx_width(DEF_NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [IDX_W-1:0]       i_last,
    output logic                   o_valid,
    output logic [IDX_W-1:0]       o_winner
);

    int   w_idx;
    logic w_found;

    always_comb begin
        w_found  = 1'b0;
        w_idx    = 0;
        o_winner = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            w_idx = (int'(i_last) + k) % NUM_MASTERS;
            if (!w_found && i_req[IDX_W'(w_idx)]) begin
                w_found  = 1'b1;
                o_winner = IDX_W'(w_idx);
            end
        end
        o_valid = w_found;
    end

endmodule

// File: rtl/pci_bus_arbiter.sv
// Central PCI arbiter: round-robin GNT# with optional parking, unused-grant
// timeout and a guaranteed dead cycle between grants to different masters.
module pci_bus_arbiter
    import pci_arb_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int PARK_EN     = 1,
    parameter int PARK_MASTER = 0,
    parameter int GNT_TIMEOUT = DEF_GNT_TIMEOUT
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            req_n,
    input  logic                              frame_n,
    input  logic                              irdy_n,
    output logic [NUM_MASTERS-1:0]            gnt_n,
    output logic [idx_width(NUM_MASTERS)-1:0] owner,
    output logic                              bus_busy,
    output logic                              timeout_pulse
);

    localparam int IDX_W = idx_width(NUM_MASTERS);
    localparam int TMR_W = timer_width(GNT_TIMEOUT);
    localparam logic [IDX_W-1:0] PARK_IDX = IDX_W'(PARK_MASTER);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_MASTERS - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GNT_TIMEOUT - 1);

    arb_state_t             r_state;
    logic [NUM_MASTERS-1:0] r_gnt_n;
    logic [IDX_W-1:0]       r_owner;
    logic [IDX_W-1:0]       r_last;
    logic [TMR_W-1:0]       r_timer;
    logic                   r_parked;
    logic                   r_busy;
    logic                   r_tout;

    arb_state_t             w_state_nxt;
    logic [NUM_MASTERS-1:0] w_gnt_n_nxt;
    logic [IDX_W-1:0]       w_owner_nxt;
    logic [IDX_W-1:0]       w_last_nxt;
    logic [TMR_W-1:0]       w_timer_nxt;
    logic                   w_parked_nxt;
    logic                   w_busy_nxt;
    logic                   w_tout_nxt;

    logic [NUM_MASTERS-1:0] w_req;
    logic [NUM_MASTERS-1:0] w_own_mask;
    logic                   w_bus_idle;
    logic                   w_others_req;
    logic                   w_own_req;
    logic                   w_own_gnt;
    logic                   w_timed_out;
    logic                   w_pick_vld;
    logic [IDX_W-1:0]       w_pick_idx;

    assign w_req        = ~req_n;
    assign w_bus_idle   = frame_n & irdy_n;
    assign w_own_mask   = NUM_MASTERS'(1) << r_owner;
    assign w_others_req = |(w_req & ~w_own_mask);
    assign w_own_req    = w_req[r_owner];
    assign w_own_gnt    = ~r_gnt_n[r_owner];
    assign w_timed_out  = (r_timer == TMR_LAST);

    rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_rr_pick (
        .i_req    (w_req),
        .i_last   (r_last),
        .o_valid  (w_pick_vld),
        .o_winner (w_pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_gnt_n  <= '1;
            r_owner  <= '0;
            r_last   <= LAST_RST;
            r_timer  <= '0;
            r_parked <= 1'b0;
            r_busy   <= 1'b0;
            r_tout   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt_n  <= w_gnt_n_nxt;
            r_owner  <= w_owner_nxt;
            r_last   <= w_last_nxt;
            r_timer  <= w_timer_nxt;
            r_parked <= w_parked_nxt;
            r_busy   <= w_busy_nxt;
            r_tout   <= w_tout_nxt;
        end
    end

    // TURN is the single all-released cycle; its exit edge already arbitrates,
    // so two different grants are separated by exactly one dead cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, TURN: begin
                if (w_bus_idle && (w_pick_vld || PARK_EN != 0))
                    w_state_nxt = GRANTED;
                else
                    w_state_nxt = IDLE;
            end
            GRANTED: begin
                if (!frame_n)
                    w_state_nxt = ACTIVE;
                else if (r_parked) begin
                    if (!w_own_req && w_others_req)
                        w_state_nxt = TURN;
                end else if (!w_own_req || w_timed_out)
                    w_state_nxt = TURN;
            end
            ACTIVE: begin
                if (w_bus_idle)
                    w_state_nxt = (w_own_req && w_own_gnt && !w_others_req) ? GRANTED : TURN;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_gnt_n_nxt  = r_gnt_n;
        w_owner_nxt  = r_owner;
        w_last_nxt   = r_last;
        w_timer_nxt  = r_timer;
        w_parked_nxt = r_parked;
        w_tout_nxt   = 1'b0;
        w_busy_nxt   = (w_state_nxt == ACTIVE);
        case (r_state)
            IDLE, TURN: begin
                w_gnt_n_nxt = '1;
                if (w_state_nxt == GRANTED) begin
                    w_owner_nxt  = w_pick_vld ? w_pick_idx : PARK_IDX;
                    w_gnt_n_nxt  = ~(NUM_MASTERS'(1) << w_owner_nxt);
                    w_parked_nxt = !w_pick_vld;
                    w_timer_nxt  = '0;
                end
            end
            GRANTED: begin
                if (!frame_n) begin
                    w_last_nxt   = r_owner;
                    w_parked_nxt = 1'b0;
                end else if (r_parked) begin
                    // Parked grants never time out until the owner actually asks.
                    if (w_own_req) begin
                        w_parked_nxt = 1'b0;
                        w_timer_nxt  = '0;
                    end else if (w_others_req)
                        w_gnt_n_nxt = '1;
                end else if (!w_own_req)
                    w_gnt_n_nxt = '1;
                else if (w_timed_out) begin
                    w_gnt_n_nxt = '1;
                    w_last_nxt  = r_owner;
                    w_tout_nxt  = 1'b1;
                end else
                    w_timer_nxt = r_timer + 1'b1;
            end
            ACTIVE: begin
                if (w_others_req || w_state_nxt == TURN)
                    w_gnt_n_nxt = '1;
                if (w_state_nxt == GRANTED)
                    w_timer_nxt = '0;
            end
            default: w_gnt_n_nxt = '1;
        endcase
    end

    assign gnt_n         = r_gnt_n;
    assign owner         = r_owner;
    assign bus_busy      = r_busy;
    assign timeout_pulse = r_tout;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Self-checking bench for pci_bus_arbiter: directed scenarios plus a randomized
// bus-agent run checked against a round-robin reference model.
module tb_pci_bus_arbiter;

    localparam int N       = 4;
    localparam int PARK_M  = 0;
    localparam int TIMEOUT = 16;

    logic         clk;
    logic         rst;
    logic [N-1:0] req_n;
    logic         frame_n;
    logic         irdy_n;
    logic [N-1:0] gnt_n;
    logic [1:0]   owner;
    logic         bus_busy;
    logic         timeout_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    // Bus agent state: the granted master runs FRAME# for tx_left edges, then
    // one IRDY#-only edge, then releases the bus.
    int tx_left  = 0;
    bit tx_tail  = 0;
    int tx_owner = 0;
    int wait_cnt = 0;

    pci_bus_arbiter #(
        .NUM_MASTERS (N),
        .PARK_EN     (1),
        .PARK_MASTER (PARK_M),
        .GNT_TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_n         (req_n),
        .frame_n       (frame_n),
        .irdy_n        (irdy_n),
        .gnt_n         (gnt_n),
        .owner         (owner),
        .bus_busy      (bus_busy),
        .timeout_pulse (timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // -1: no grant, -2: more than one grant, otherwise the granted index
    function automatic int gnt_idx(input logic [N-1:0] g);
        int hits;
        int idx;
        hits = 0;
        idx  = -1;
        for (int i = 0; i < N; i++)
            if (g[i] === 1'b0) begin
                hits++;
                idx = i;
            end
        if (hits > 1 || $isunknown(g)) return -2;
        return idx;
    endfunction

    function automatic int rr_ref(input int last, input logic [N-1:0] rq_n);
        int p;
        for (int k = 1; k <= N; k++) begin
            p = (last + k) % N;
            if (rq_n[p[1:0]] == 1'b0) return p;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst      = 1'b1;
        req_n    = '1;
        frame_n  = 1'b1;
        irdy_n   = 1'b1;
        tx_left  = 0;
        tx_tail  = 1'b0;
        wait_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic agent_step(input int flen, input bit eager);
        int m;
        if (tx_left > 0) begin
            tx_left--;
            if (tx_left == 0) begin
                frame_n = 1'b1;
                tx_tail = 1'b1;
            end
        end else if (tx_tail) begin
            tx_tail = 1'b0;
            irdy_n  = 1'b1;
        end else begin
            m = gnt_idx(gnt_n);
            if (m >= 0 && req_n[m[1:0]] == 1'b0) begin
                if (eager || wait_cnt >= 3 || $urandom_range(0, 3) != 0) begin
                    frame_n  = 1'b0;
                    irdy_n   = 1'b0;
                    tx_left  = flen;
                    tx_owner = m;
                    wait_cnt = 0;
                end else
                    wait_cnt++;
            end else
                wait_cnt = 0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (gnt_n !== 4'b1111) begin n_fail++; $display("FAIL reset_gnt: got %b want 1111", gnt_n); end
        n_checks++;
        if (owner !== 2'd0) begin n_fail++; $display("FAIL reset_owner: got %0d want 0", owner); end
        n_checks++;
        if (bus_busy !== 1'b0 || timeout_pulse !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: busy %b tout %b want 0 0", bus_busy, timeout_pulse);
        end
    endtask

    task automatic test_park();
        do_reset();
        @(negedge clk);
        n_checks++;
        if (gnt_n !== 4'b1110) begin n_fail++; $display("FAIL park_gnt: got %b want 1110", gnt_n); end
        req_n = 4'b1011;
        @(negedge clk);
        n_checks++;
        if (gnt_n !== 4'b1111) begin n_fail++; $display("FAIL park_dead_cycle: got %b want 1111", gnt_n); end
        @(negedge clk);
        n_checks++;
        if (gnt_n !== 4'b1011) begin n_fail++; $display("FAIL park_handover_gnt: got %b want 1011", gnt_n); end
        n_checks++;
        if (owner !== 2'd2) begin n_fail++; $display("FAIL park_handover_owner: got %0d want 2", owner); end
    endtask

    task automatic test_rotation();
        int order[5];
        int n_gr;
        int prev;
        int cur;
        bit moved;
        do_reset();
        req_n = 4'b0000;
        prev  = -1;
        n_gr  = 0;
        moved = 1'b0;
        for (int i = 0; i < 5; i++) order[i] = -1;
        for (int cyc = 0; cyc < 300 && n_gr < 5; cyc++) begin
            @(negedge clk);
            cur = gnt_idx(gnt_n);
            if (prev >= 0 && cur >= 0 && cur != prev) moved = 1'b1;
            if (prev == -1 && cur >= 0) begin
                order[n_gr] = cur;
                n_gr++;
            end
            prev = cur;
            agent_step(3, 1'b1);
        end
        n_checks++;
        if (n_gr != 5) begin n_fail++; $display("FAIL rot_count: got %0d grants want 5", n_gr); end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (order[i] != i % N) begin
                n_fail++; $display("FAIL rot_order[%0d]: got %0d want %0d", i, order[i], i % N);
            end
        end
        n_checks++;
        if (moved) begin n_fail++; $display("FAIL rot_direct_move: got 1 want 0"); end
    endtask

    task automatic test_timeout();
        int low_cycles;
        bit early_pulse;
        do_reset();
        req_n = 4'b1101;
        @(negedge clk);
        low_cycles  = (gnt_n === 4'b1101) ? 1 : 0;
        early_pulse = timeout_pulse;
        req_n = 4'b0101;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (gnt_n !== 4'b1101) break;
            low_cycles++;
            if (timeout_pulse) early_pulse = 1'b1;
        end
        n_checks++;
        if (low_cycles != TIMEOUT) begin n_fail++; $display("FAIL tout_len: got %0d want %0d", low_cycles, TIMEOUT); end
        n_checks++;
        if (gnt_n !== 4'b1111 || timeout_pulse !== 1'b1) begin
            n_fail++; $display("FAIL tout_revoke: gnt %b pulse %b want 1111 1", gnt_n, timeout_pulse);
        end
        n_checks++;
        if (early_pulse) begin n_fail++; $display("FAIL tout_early_pulse: got 1 want 0"); end
        @(negedge clk);
        n_checks++;
        if (timeout_pulse !== 1'b0) begin n_fail++; $display("FAIL tout_pulse_width: got %b want 0", timeout_pulse); end
        n_checks++;
        if (gnt_n !== 4'b0111 || owner !== 2'd3) begin
            n_fail++; $display("FAIL tout_next: gnt %b owner %0d want 0111 3", gnt_n, owner);
        end
    endtask

    task automatic test_preempt();
        do_reset();
        req_n = 4'b1110;
        @(negedge clk);
        n_checks++;
        if (gnt_n !== 4'b1110) begin n_fail++; $display("FAIL pre_grant: got %b want 1110", gnt_n); end
        frame_n = 1'b0;
        irdy_n  = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus_busy !== 1'b1 || gnt_n !== 4'b1110) begin
            n_fail++; $display("FAIL pre_active: busy %b gnt %b want 1 1110", bus_busy, gnt_n);
        end
        req_n = 4'b0110;
        @(negedge clk);
        n_checks++;
        if (gnt_n !== 4'b1111 || bus_busy !== 1'b1) begin
            n_fail++; $display("FAIL pre_revoke: gnt %b busy %b want 1111 1", gnt_n, bus_busy);
        end
        @(negedge clk);
        frame_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus_busy !== 1'b1) begin n_fail++; $display("FAIL pre_busy_irdy: got %b want 1", bus_busy); end
        irdy_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus_busy !== 1'b0 || gnt_n !== 4'b1111) begin
            n_fail++; $display("FAIL pre_turn: busy %b gnt %b want 0 1111", bus_busy, gnt_n);
        end
        @(negedge clk);
        n_checks++;
        if (gnt_n !== 4'b0111 || owner !== 2'd3) begin
            n_fail++; $display("FAIL pre_next: gnt %b owner %0d want 0111 3", gnt_n, owner);
        end
    endtask

    task automatic test_back_to_back();
        int  starts;
        logic pf;
        do_reset();
        req_n  = 4'b1011;
        starts = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge clk);
            n_checks++;
            if (gnt_n !== 4'b1011) begin
                n_fail++; $display("FAIL b2b_gnt cycle %0d: got %b want 1011", cyc, gnt_n);
            end
            pf = frame_n;
            agent_step(2, 1'b1);
            if (pf && !frame_n) starts++;
        end
        n_checks++;
        if (starts < 3) begin n_fail++; $display("FAIL b2b_starts: got %0d want >=3", starts); end
    endtask

    task automatic test_reset_active();
        do_reset();
        req_n = 4'b1101;
        @(negedge clk);
        frame_n = 1'b0;
        irdy_n  = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus_busy !== 1'b1) begin n_fail++; $display("FAIL rsta_active: busy %b want 1", bus_busy); end
        req_n = 4'b0000;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (gnt_n !== 4'b1111 || bus_busy !== 1'b0) begin
            n_fail++; $display("FAIL rsta_async: gnt %b busy %b want 1111 0", gnt_n, bus_busy);
        end
        frame_n = 1'b1;
        irdy_n  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (gnt_n !== 4'b1110 || owner !== 2'd0) begin
            n_fail++; $display("FAIL rsta_first: gnt %b owner %0d want 1110 0", gnt_n, owner);
        end
    endtask

    task automatic test_random();
        int   m_last;
        int   prev_g;
        int   cur;
        int   exp_g;
        int   started;
        logic prev_frame;
        do_reset();
        m_last     = N - 1;
        prev_g     = -1;
        prev_frame = 1'b1;
        req_n      = 4'($urandom_range(0, 15));
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            cur = gnt_idx(gnt_n);
            n_checks++;
            if (cur == -2) begin n_fail++; $display("FAIL rnd_onehot cyc %0d: got %b want one-hot-low or 1111", cyc, gnt_n); end
            n_checks++;
            if (prev_g >= 0 && cur >= 0 && cur != prev_g) begin
                n_fail++; $display("FAIL rnd_direct_move cyc %0d: got %0d->%0d want a dead cycle", cyc, prev_g, cur);
            end
            if (prev_frame && !frame_n) m_last = tx_owner;
            if (prev_g == -1 && cur >= 0) begin
                exp_g = rr_ref(m_last, req_n);
                if (exp_g < 0) exp_g = PARK_M;
                n_checks++;
                if (cur != exp_g) begin
                    n_fail++; $display("FAIL rnd_rr cyc %0d: got %0d want %0d (req_n %b last %0d)", cyc, cur, exp_g, req_n, m_last);
                end
            end
            if (cur >= 0) begin
                n_checks++;
                if (owner !== cur[1:0]) begin n_fail++; $display("FAIL rnd_owner cyc %0d: got %0d want %0d", cyc, owner, cur); end
            end
            n_checks++;
            if (bus_busy !== !(frame_n && irdy_n)) begin
                n_fail++; $display("FAIL rnd_busy cyc %0d: got %b want %b", cyc, bus_busy, !(frame_n && irdy_n));
            end
            n_checks++;
            if (timeout_pulse !== 1'b0) begin n_fail++; $display("FAIL rnd_tout cyc %0d: got %b want 0", cyc, timeout_pulse); end
            prev_g     = cur;
            prev_frame = frame_n;
            started    = -1;
            if (!frame_n) started = -1;
            begin
                logic pf;
                pf = frame_n;
                agent_step($urandom_range(1, 4), 1'b0);
                if (pf && !frame_n) started = tx_owner;
            end
            for (int m = 0; m < N; m++)
                if (m != started && $urandom_range(0, 7) == 0)
                    req_n[m] = ~req_n[m];
        end
    endtask

    initial begin
        test_reset();
        test_park();
        test_rotation();
        test_timeout();
        test_preempt();
        test_back_to_back();
        test_reset_active();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
